// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin sharing of one calculator between requesters A and B
module calc_arbiter #(
   parameter int TIMEOUT = 63,
   parameter int TW      = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_a,
   input  logic [3:0] x_a,
   input  logic [3:0] y_a,
   input  logic [2:0] f_a,
   input  logic       req_b,
   input  logic [3:0] x_b,
   input  logic [3:0] y_b,
   input  logic [2:0] f_b,
   output logic       gnt_a,
   output logic       gnt_b,
   output logic       calc_go,
   output logic [3:0] calc_x,
   output logic [3:0] calc_y,
   output logic [2:0] calc_f,
   input  logic       calc_done,
   input  logic [3:0] calc_out_h,
   input  logic [3:0] calc_out_l,
   output logic       rsp_valid,
   output logic       rsp_id,
   output logic [3:0] rsp_h,
   output logic [3:0] rsp_l,
   output logic       rsp_err,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t        state_q;
   logic          last_q;
   logic          id_q;
   logic [3:0]    x_q;
   logic [3:0]    y_q;
   logic [2:0]    f_q;
   logic [3:0]    h_q;
   logic [3:0]    l_q;
   logic          err_q;
   logic [TW-1:0] cnt_q;
   logic          pick_b;
   logic          idle;
   // B wins when it is the only requester, or on a tie when A was served last
   assign pick_b    = req_b && (!req_a || !last_q);
   assign idle      = !rst && state_q == IDLE;
   assign gnt_a     = idle && req_a && !pick_b;
   assign gnt_b     = idle && pick_b;
   assign calc_go   = state_q == ISSUE || state_q == WAIT;
   assign rsp_valid = state_q == RESP;
   assign busy      = state_q != IDLE;
   assign calc_x    = x_q;
   assign calc_y    = y_q;
   assign calc_f    = f_q;
   assign rsp_id    = id_q;
   assign rsp_h     = h_q;
   assign rsp_l     = l_q;
   assign rsp_err   = err_q;
   // sequencer: grant, issue, wait for done or timeout, respond
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         f_q     <= '0;
         h_q     <= '0;
         l_q     <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (req_a || req_b) begin
               x_q     <= pick_b ? x_b : x_a;
               y_q     <= pick_b ? y_b : y_a;
               f_q     <= pick_b ? f_b : f_a;
               id_q    <= pick_b;
               state_q <= ISSUE;
            end
            ISSUE: begin
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_q + TW'(1);
               if (calc_done) begin
                  h_q     <= calc_out_h;
                  l_q     <= calc_out_l;
                  err_q   <= 1'b0;
                  state_q <= RESP;
               end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                  h_q     <= '0;
                  l_q     <= '0;
                  err_q   <= 1'b1;
                  state_q <= RESP;
               end
            end
            default: begin
               last_q  <= id_q;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule
